// File: rtl/rtc_updown_timer_pkg.sv
// rtl/rtc_updown_timer_pkg.sv - shared types, field limits and preset clamp helper
// Purpose: time_t layout used by the timer top, field maxima and clamp_time().
// Ports: none (package).
package rtc_pkg;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic [9:0] msec;
  } time_t;

  localparam int MSEC_MAX = 999;
  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;

  // Out-of-range preset values saturate to the field maximum rather than wrap.
  function automatic time_t clamp_time(input time_t t, input int hours);
    time_t r;
    r = t;
    if (int'(t.msec) > MSEC_MAX)  r.msec = 10'(MSEC_MAX);
    if (int'(t.sec)  > SEC_MAX)   r.sec  = 6'(SEC_MAX);
    if (int'(t.min)  > MIN_MAX)   r.min  = 6'(MIN_MAX);
    if (int'(t.hour) > hours - 1) r.hour = 5'(hours - 1);
    return r;
  endfunction

endpackage

// File: rtl/rtc_updown_timer_if.sv
// rtl/rtc_updown_timer_if.sv - control, preset and time/pulse bundle of the timer
// Purpose: groups every non-clock/reset signal of rtc_updown_timer.
// Ports: master drives run/down/preset/alarm_we and preset buses, reads time and pulses;
//        slave is the timer side.
interface rtc_updown_timer_if;

  logic       run_i;
  logic       down_i;
  logic       preset_i;
  logic       alarm_we_i;
  logic [9:0] msec_preset;
  logic [5:0] sec_preset;
  logic [5:0] min_preset;
  logic [4:0] hour_preset;
  logic [9:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic       tick_o;
  logic       wrap_o;
  logic       done_o;
  logic       alarm_o;

  modport master (
    output run_i, down_i, preset_i, alarm_we_i,
    output msec_preset, sec_preset, min_preset, hour_preset,
    input  msec, sec, min, hour, tick_o, wrap_o, done_o, alarm_o
  );

  modport slave (
    input  run_i, down_i, preset_i, alarm_we_i,
    input  msec_preset, sec_preset, min_preset, hour_preset,
    output msec, sec, min, hour, tick_o, wrap_o, done_o, alarm_o
  );

endinterface

// File: rtl/rtc_updown_timer_digit.sv
// rtl/rtc_updown_timer_digit.sv - one modulo-(MAX+1) up/down time field
// Purpose: single time field with load, enable and carry/borrow out.
// Ports: clk_i/rst_i clock and async reset; en advance; down direction; load/load_value
//        synchronous load (wins over en); value_o current; next_o value after this edge;
//        carry_o set when en and the field is about to wrap (MAX up, 0 down).
module rtc_digit #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en,
  input  logic             down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] next_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_value;
    end else if (en) begin
      if (down) value_d = (value_q == '0)    ? MAX_V : value_q - ONE_V;
      else      value_d = (value_q == MAX_V) ? '0    : value_q + ONE_V;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) value_q <= '0;
    else       value_q <= value_d;
  end

  assign carry_o = en && (down ? (value_q == '0) : (value_q == MAX_V));
  assign value_o = value_q;
  assign next_o  = value_d;

endmodule

// File: rtl/rtc_updown_timer.sv
// rtl/rtc_updown_timer.sv - prescaled hour:min:sec:msec up/down timer with alarm
// Purpose: divides clk_i by CLK_FREQ/TICK_FREQ and advances the time fields each tick,
//          counting up (wall clock) or down (saturating countdown), with preset and alarm.
// Ports: clk_i clock; rst_i async active-high reset; bus (slave) carries run/down/preset/
//        alarm_we controls, preset buses, time fields and the tick/wrap/done/alarm pulses.
module rtc_updown_timer
  import rtc_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_FREQ = 1000,
  parameter int HOURS     = 24
) (
  input logic              clk_i,
  input logic              rst_i,
  rtc_updown_timer_if.slave bus
);

  // DIV must be >= 2, so PW is at least 1.
  localparam int            DIV        = CLK_FREQ / TICK_FREQ;
  localparam int            PW         = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          done_q, done_d;
  logic          alarm_q, alarm_d;
  time_t         alarm_time_q, alarm_time_d;

  time_t      preset_raw, preset_val, cur, nxt;
  logic       tick_en, fire, at_zero, en_msec;
  logic       c_msec, c_sec, c_min, c_hour;
  logic [9:0] msec_v, msec_n;
  logic [5:0] sec_v, sec_n, min_v, min_n;
  logic [4:0] hour_v, hour_n;

  assign preset_raw = {bus.hour_preset, bus.min_preset, bus.sec_preset, bus.msec_preset};
  assign preset_val = clamp_time(preset_raw, HOURS);

  assign cur = {hour_v, min_v, sec_v, msec_v};
  assign nxt = {hour_n, min_n, sec_n, msec_n};

  // A tick due in the same cycle as a preset is dropped: the preset owns the fields.
  assign tick_en = bus.run_i && (presc_q == PRESC_LAST);
  assign fire    = tick_en && !bus.preset_i;
  assign at_zero = (cur == '0);
  // Down-count saturates at zero: the tick still pulses but no field moves.
  assign en_msec = fire && !(bus.down_i && at_zero);

  rtc_digit #(.WIDTH(10), .MAX(MSEC_MAX)) u_msec (
    .clk_i(clk_i), .rst_i(rst_i), .en(en_msec), .down(bus.down_i),
    .load(bus.preset_i), .load_value(preset_val.msec),
    .value_o(msec_v), .next_o(msec_n), .carry_o(c_msec)
  );

  rtc_digit #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
    .clk_i(clk_i), .rst_i(rst_i), .en(c_msec), .down(bus.down_i),
    .load(bus.preset_i), .load_value(preset_val.sec),
    .value_o(sec_v), .next_o(sec_n), .carry_o(c_sec)
  );

  rtc_digit #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
    .clk_i(clk_i), .rst_i(rst_i), .en(c_sec), .down(bus.down_i),
    .load(bus.preset_i), .load_value(preset_val.min),
    .value_o(min_v), .next_o(min_n), .carry_o(c_min)
  );

  rtc_digit #(.WIDTH(5), .MAX(HOURS - 1)) u_hour (
    .clk_i(clk_i), .rst_i(rst_i), .en(c_min), .down(bus.down_i),
    .load(bus.preset_i), .load_value(preset_val.hour),
    .value_o(hour_v), .next_o(hour_n), .carry_o(c_hour)
  );

  always_comb begin
    presc_d = presc_q;
    if (bus.preset_i)    presc_d = '0;
    else if (bus.run_i)  presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_ONE;

    alarm_time_d = alarm_time_q;
    if (bus.alarm_we_i) alarm_time_d = {preset_val.hour, preset_val.min, preset_val.sec, 10'd0};

    tick_d  = fire;
    // Hour carrying out on an up tick means every field was at its maximum.
    wrap_d  = fire && !bus.down_i && c_hour;
    done_d  = fire && bus.down_i && !at_zero && (nxt == '0);
    // Alarm register holds msec = 0, so a full compare also requires msec == 0.
    alarm_d = fire && (nxt == alarm_time_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc_q      <= '0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
      done_q       <= 1'b0;
      alarm_q      <= 1'b0;
      alarm_time_q <= '0;
    end else begin
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
      done_q       <= done_d;
      alarm_q      <= alarm_d;
      alarm_time_q <= alarm_time_d;
    end
  end

  assign bus.msec    = msec_v;
  assign bus.sec     = sec_v;
  assign bus.min     = min_v;
  assign bus.hour    = hour_v;
  assign bus.tick_o  = tick_q;
  assign bus.wrap_o  = wrap_q;
  assign bus.done_o  = done_q;
  assign bus.alarm_o = alarm_q;

endmodule

// File: tb/tb_rtc_updown_timer.sv
// tb/tb_rtc_updown_timer.sv - self-checking bench for rtc_updown_timer (DIV = 4, 24 h)
module tb_rtc_updown_timer;

  localparam int unsigned DAY_MS = 24 * 3600000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rtc_updown_timer_if bus ();

  rtc_updown_timer #(.CLK_FREQ(4000), .TICK_FREQ(1000), .HOURS(24)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: time as total milliseconds since midnight, prescaler as a phase.
  int unsigned m_t, m_ph, m_al;
  bit          m_tick, m_wrap, m_done, m_alarm;

  typedef struct {
    int          h;
    int          m;
    int          s;
    int          ms;
    logic [31:0] exp;
  } clamp_vec_t;
  clamp_vec_t vecs[6];

  function automatic logic [31:0] tv(input int h, input int m, input int s, input int ms);
    return {5'd0, 5'(h), 6'(m), 6'(s), 10'(ms)};
  endfunction

  function automatic logic [31:0] dut_time();
    return {5'd0, bus.hour, bus.min, bus.sec, bus.msec};
  endfunction

  function automatic logic [31:0] dut_pulse();
    return {28'd0, bus.tick_o, bus.wrap_o, bus.done_o, bus.alarm_o};
  endfunction

  function automatic logic [31:0] model_time();
    return tv(int'(m_t / 3600000), int'((m_t / 60000) % 60), int'((m_t / 1000) % 60),
              int'(m_t % 1000));
  endfunction

  function automatic int unsigned clamp_ms(input int h, input int m, input int s, input int ms);
    int ch, cm, cs, cms;
    ch  = (h > 23) ? 23 : h;
    cm  = (m > 59) ? 59 : m;
    cs  = (s > 59) ? 59 : s;
    cms = (ms > 999) ? 999 : ms;
    return int'(ch * 3600000 + cm * 60000 + cs * 1000 + cms);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_ph = 0; m_al = 0;
    m_tick = 0; m_wrap = 0; m_done = 0; m_alarm = 0;
  endtask

  task automatic model_step();
    int h, m, s, ms;
    h  = int'(bus.hour_preset);
    m  = int'(bus.min_preset);
    s  = int'(bus.sec_preset);
    ms = int'(bus.msec_preset);
    m_tick = 0; m_wrap = 0; m_done = 0; m_alarm = 0;
    if (bus.preset_i) begin
      m_t  = clamp_ms(h, m, s, ms);
      m_ph = 0;
    end else if (bus.run_i) begin
      if (m_ph == 3) begin
        m_ph   = 0;
        m_tick = 1;
        if (bus.down_i) begin
          if (m_t != 0) begin
            m_t    = m_t - 1;
            m_done = (m_t == 0);
          end
        end else begin
          m_t    = (m_t + 1) % DAY_MS;
          m_wrap = (m_t == 0);
        end
        m_alarm = (m_t == m_al);
      end else begin
        m_ph = m_ph + 1;
      end
    end
    if (bus.alarm_we_i) m_al = clamp_ms(h, m, s, 0);
  endtask

  // One clock: inputs are stable across the edge, outputs are sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("model_time", dut_time(), model_time());
    chk("model_pulse", dut_pulse(), {28'd0, m_tick, m_wrap, m_done, m_alarm});
  endtask

  task automatic set_bus(input int h, input int m, input int s, input int ms);
    bus.hour_preset = 5'(h);
    bus.min_preset  = 6'(m);
    bus.sec_preset  = 6'(s);
    bus.msec_preset = 10'(ms);
  endtask

  task automatic do_preset(input int h, input int m, input int s, input int ms);
    set_bus(h, m, s, ms);
    bus.preset_i = 1'b1;
    cyc();
    bus.preset_i = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (4 * n) cyc();
  endtask

  task automatic rand_bus();
    case ($urandom_range(0, 4))
      0:       set_bus(23, 59, 59, 985 + int'($urandom_range(0, 20)));
      1:       set_bus(0, 0, 0, int'($urandom_range(0, 30)));
      2:       set_bus(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                       int'($urandom_range(0, 63)), int'($urandom_range(0, 1023)));
      3:       set_bus(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)),
                       int'($urandom_range(0, 59)), int'($urandom_range(0, 40)));
      default: set_bus(0, 0, 1, int'($urandom_range(0, 30)));
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ticks;
    logic [11:0] tick_map;
    logic [31:0] frozen;

    vecs[0] = '{30, 60, 63, 1023, tv(23, 59, 59, 999)};
    vecs[1] = '{24, 59, 59, 1000, tv(23, 59, 59, 999)};
    vecs[2] = '{23, 0, 60, 999, tv(23, 0, 59, 999)};
    vecs[3] = '{0, 0, 0, 0, tv(0, 0, 0, 0)};
    vecs[4] = '{12, 61, 30, 500, tv(12, 59, 30, 500)};
    vecs[5] = '{31, 59, 62, 998, tv(23, 59, 59, 998)};

    bus.run_i = 1'b0; bus.down_i = 1'b0; bus.preset_i = 1'b0; bus.alarm_we_i = 1'b0;
    set_bus(0, 0, 0, 0);
    model_reset();

    // Reset state
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_time", dut_time(), tv(0, 0, 0, 0));
    chk("reset_pulse", dut_pulse(), 32'd0);
    rst = 1'b0;

    // 12 clocks counting up: ticks on clocks 4, 8, 12
    bus.run_i = 1'b1;
    tick_map = '0;
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      tick_map[i] = bus.tick_o;
      if (bus.tick_o) ticks++;
    end
    chk("first_msec", dut_time(), tv(0, 0, 0, 3));
    chk("tick_count", 32'(ticks), 32'd3);
    chk("tick_positions", {20'd0, tick_map}, 32'h888);

    // Up-count wrap at end of day
    do_preset(23, 59, 59, 998);
    tick_n(1);
    chk("pre_wrap_time", dut_time(), tv(23, 59, 59, 999));
    chk("pre_wrap_flag", 32'(bus.wrap_o), 32'd0);
    tick_n(1);
    chk("wrap_time", dut_time(), tv(0, 0, 0, 0));
    chk("wrap_flag", 32'(bus.wrap_o), 32'd1);
    cyc();
    chk("wrap_one_cycle", 32'(bus.wrap_o), 32'd0);

    // Down count with borrow, done and saturation
    bus.down_i = 1'b1;
    do_preset(0, 0, 1, 1);
    tick_n(2);
    chk("borrow_time", dut_time(), tv(0, 0, 0, 999));
    do_preset(0, 0, 0, 1);
    tick_n(1);
    chk("done_time", dut_time(), tv(0, 0, 0, 0));
    chk("done_flag", 32'(bus.done_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick_n(1);
      chk("sat_time", dut_time(), tv(0, 0, 0, 0));
      chk("sat_tick", 32'(bus.tick_o), 32'd1);
      chk("sat_no_done", 32'(bus.done_o), 32'd0);
    end

    // Alarm fires on a tick, not on a preset
    bus.down_i = 1'b0;
    set_bus(0, 0, 1, 0);
    bus.alarm_we_i = 1'b1;
    cyc();
    bus.alarm_we_i = 1'b0;
    do_preset(0, 0, 0, 999);
    tick_n(1);
    chk("alarm_time", dut_time(), tv(0, 0, 1, 0));
    chk("alarm_fire", 32'(bus.alarm_o), 32'd1);
    do_preset(0, 0, 1, 0);
    chk("alarm_preset_quiet", 32'(bus.alarm_o), 32'd0);

    // Clamp table, paused so no ticks interfere
    bus.run_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      do_preset(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].ms);
      chk($sformatf("clamp_%0d", i), dut_time(), vecs[i].exp);
      chk($sformatf("clamp_pulse_%0d", i), dut_pulse(), 32'd0);
    end

    // Preset coincident with a due tick wins and restarts the prescaler
    bus.run_i = 1'b1;
    do_preset(5, 6, 7, 8);
    repeat (3) cyc();
    do_preset(10, 20, 30, 400);
    chk("preset_wins_time", dut_time(), tv(10, 20, 30, 400));
    chk("preset_wins_tick", 32'(bus.tick_o), 32'd0);
    repeat (3) cyc();
    chk("restart_no_tick", 32'(bus.tick_o), 32'd0);
    cyc();
    chk("restart_tick", 32'(bus.tick_o), 32'd1);
    chk("restart_time", dut_time(), tv(10, 20, 30, 401));

    // Pause mid-count: fields and prescaler phase frozen
    do_preset(1, 2, 3, 4);
    cyc();
    cyc();
    bus.run_i = 1'b0;
    frozen = dut_time();
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pause_time", dut_time(), frozen);
      chk("pause_tick", 32'(bus.tick_o), 32'd0);
    end
    bus.run_i = 1'b1;
    cyc();
    chk("resume_no_tick", 32'(bus.tick_o), 32'd0);
    cyc();
    chk("resume_tick", 32'(bus.tick_o), 32'd1);
    chk("resume_time", dut_time(), tv(1, 2, 3, 5));

    // Asynchronous reset mid-cycle
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_time", dut_time(), tv(0, 0, 0, 0));
    chk("async_rst_pulse", dut_pulse(), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomised run against the model
    for (int i = 0; i < 3000; i++) begin
      bus.run_i      = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 199) == 0) bus.down_i = ~bus.down_i;
      bus.preset_i   = ($urandom_range(0, 149) == 0);
      bus.alarm_we_i = ($urandom_range(0, 99) == 0) || (bus.preset_i && ($urandom_range(0, 1) == 1));
      if (bus.preset_i || bus.alarm_we_i) rand_bus();
      cyc();
    end
    bus.preset_i = 1'b0;
    bus.alarm_we_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_updown_timer.md
Name: rtc_updown_timer

Overview:
- Parametrised successor to the fixed 50 MHz time-of-day counter.
- Divides clk_i to a programmable tick rate and keeps hour:min:sec:msec time.
- Counts up as a wall clock or down as a countdown timer, with run/pause control, preset load and a programmable alarm.
- Sits under the lab top level, feeding display and bell logic.

Parameters:
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- TICK_FREQ, 1000, msec-field update rate in Hz; DIV = CLK_FREQ/TICK_FREQ, must be >= 2.
- HOURS, 24, hour field modulus (12 or 24 only).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- run_i  in  1  1 = prescaler advances; 0 = paused, all state held.
- down_i  in  1  0 = count up, 1 = count down.
- preset_i  in  1  load time fields from the preset buses.
- alarm_we_i  in  1  load alarm register (hour, min, sec) from the preset buses.
- msec_preset  in  10  preset msec.
- sec_preset  in  6  preset sec.
- min_preset  in  6  preset min.
- hour_preset  in  5  preset hour.
- msec  out  10  current msec.
- sec  out  6  current sec.
- min  out  6  current min.
- hour  out  5  current hour.
- tick_o  out  1  one-cycle pulse when the time fields update.
- wrap_o  out  1  one-cycle pulse on up-count wrap from (HOURS-1):59:59:999 to 0.
- done_o  out  1  one-cycle pulse when a down-count reaches 0:00:00:000.
- alarm_o  out  1  one-cycle pulse when a tick makes the time equal the alarm.

Behaviour:
- Reset (asynchronous): all time fields, prescaler, alarm register and pulse outputs go to 0.
- Prescaler:
  - Counts 0..DIV-1 while run_i = 1 and holds while run_i = 0.
  - The time fields update on the cycle the prescaler equals DIV-1 with run_i = 1. tick_o is registered and asserts in that same cycle, aligned with the new field values.
- Preset:
  - preset_i takes priority over a tick in the same cycle.
  - Loads all four fields and clears the prescaler.
  - Clamps out-of-range values to the field maximum: msec 999, sec/min 59, hour HOURS-1.
  - Generates no tick/wrap/done/alarm pulse.
- alarm_we_i:
  - Loads the alarm register with clamped hour/min/sec.
  - May coincide with preset_i; both loads occur.
- Up count (down_i = 0):
  - msec increments each tick and wraps 999 -> 0.
  - Each field carries into the next only when all lower fields are at their maximum.
  - hour wraps HOURS-1 -> 0, and wrap_o pulses with the all-zero result.
- Down count (down_i = 1):
  - msec decrements with borrow; each field reloads its maximum when it borrows.
  - At 0:00:00:000 the counter saturates, and further ticks leave the fields unchanged.
  - done_o pulses once, on the tick that produces zero. Ticks while already at zero give no done_o; tick_o still pulses.
- down_i may change at any time; the new direction applies from the next tick.
- Alarm:
  - Compares the post-tick value against the alarm hour:min:sec with msec == 0.
  - alarm_o pulses in the cycle tick_o asserts, in either direction. Preset to the alarm time does not fire it.
- Pulse outputs are registered and never exceed one cycle.

Decomposition:
- Package rtc_pkg:
  - time_t packed struct {hour[4:0], min[5:0], sec[5:0], msec[9:0]}.
  - Constants MSEC_MAX = 999, SEC_MAX = 59, MIN_MAX = 59.
  - Function clamp_time(time_t, hours) returning time_t.
- Sub-module rtc_digit, one per field:
  - Parameters WIDTH and MAX.
  - Inputs en, down, load, load_value.
  - Output carry_o, asserted when en and (value == MAX up / value == 0 down).
  - The top-level cascades the carry_o outputs.

Test Plan (CLK_FREQ = 4000, TICK_FREQ = 1000, so DIV = 4):
- Reset, run_i = 1, down_i = 0, 12 clocks -> msec = 3, tick_o every 4th cycle, exactly 3 pulses.
- Preset 23:59:59:998, HOURS = 24, run up for 2 ticks -> 23:59:59:999, then 0:00:00:000 with wrap_o = 1 for one cycle.
- Preset 0:00:01:001, down_i = 1, 2 ticks -> 0:00:00:999; preset 0:00:00:001, 1 tick -> zero with done_o = 1; 3 more ticks -> stays zero, no done_o.
- Alarm 0:00:01, preset 0:00:00:999 up -> the next tick gives 0:00:01:000 and alarm_o = 1. Re-preset to 0:00:01:000 -> no alarm_o.
- Preset sec = 63, hour = 30 -> reads sec 59, hour 23. preset_i coincident with a tick -> preset value wins, no tick_o.
- run_i = 0 for 10 cycles mid-count -> fields and prescaler frozen. rst_i asserted mid-cycle (asynchronous) -> outputs 0 immediately.
